// File: rtl/universal_gate_checker.sv
// universal_gate_checker: sweeps a NAND/NOR gate through all input vectors and scores its responses.
// Define UNIVERSAL_GATE_CHECKER_FIRST_FAIL_EN to expose the first mismatching vector and its observed outputs.
module universal_gate_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES = 1,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             nand_in,
  input  logic             nor_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_mask
`ifdef UNIVERSAL_GATE_CHECKER_FIRST_FAIL_EN
  ,
  output logic [1:0]       first_fail_vec,
  output logic [1:0]       first_fail_obs
`endif
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int PW = $clog2(PASSES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [PW-1:0]    pass_cnt_q, pass_cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       mask_q, mask_d;
  logic             nand_bad, nor_bad;
  logic [ERR_W:0]   err_sum;
  logic [ERR_W-1:0] err_sat;
`ifdef UNIVERSAL_GATE_CHECKER_FIRST_FAIL_EN
  logic       ff_seen_q, ff_seen_d;
  logic [1:0] ff_vec_q, ff_vec_d, ff_obs_q, ff_obs_d;
  assign first_fail_vec = ff_vec_q;
  assign first_fail_obs = ff_obs_q;
`endif
  assign nand_bad = nand_in != ~(vec_q[1] & vec_q[0]);
  assign nor_bad  = nor_in != ~(vec_q[1] | vec_q[0]);
  // One extra bit catches overflow of the 0..2 increment so the count can clamp.
  assign err_sum  = {1'b0, err_q} + (ERR_W+1)'(nand_bad) + (ERR_W+1)'(nor_bad);
  assign err_sat  = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
  assign a_out     = vec_q[1];
  assign b_out     = vec_q[0];
  assign busy      = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done      = state_q == DONE;
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign fail_mask = mask_q;
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    settle_d   = settle_q;
    pass_cnt_d = pass_cnt_q;
    err_d      = err_q;
    mask_d     = mask_q;
`ifdef UNIVERSAL_GATE_CHECKER_FIRST_FAIL_EN
    ff_seen_d  = ff_seen_q;
    ff_vec_d   = ff_vec_q;
    ff_obs_d   = ff_obs_q;
`endif
    if ((state_q == IDLE || state_q == DONE) && start) begin
      state_d    = SETTLE;
      vec_d      = 2'b00;
      settle_d   = '0;
      pass_cnt_d = '0;
      err_d      = '0;
      mask_d     = '0;
`ifdef UNIVERSAL_GATE_CHECKER_FIRST_FAIL_EN
      ff_seen_d  = 1'b0;
      ff_vec_d   = 2'b00;
      ff_obs_d   = 2'b00;
`endif
    end else if (state_q == SETTLE) begin
      settle_d = (settle_q == SETTLE_LAST) ? '0 : settle_q + 1'b1;
      state_d  = (settle_q == SETTLE_LAST) ? SAMPLE : SETTLE;
    end else if (state_q == SAMPLE) begin
      err_d = err_sat;
      if (nand_bad || nor_bad) mask_d[vec_q] = 1'b1;
`ifdef UNIVERSAL_GATE_CHECKER_FIRST_FAIL_EN
      if ((nand_bad || nor_bad) && !ff_seen_q) begin
        ff_seen_d = 1'b1;
        ff_vec_d  = vec_q;
        ff_obs_d  = {nand_in, nor_in};
      end
`endif
      if (vec_q != 2'b11) begin
        vec_d   = vec_q + 1'b1;
        state_d = SETTLE;
      end else if (pass_cnt_q != PASS_LAST) begin
        vec_d      = 2'b00;
        pass_cnt_d = pass_cnt_q + 1'b1;
        state_d    = SETTLE;
      end else begin
        state_d = DONE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      settle_q   <= '0;
      pass_cnt_q <= '0;
      err_q      <= '0;
      mask_q     <= '0;
`ifdef UNIVERSAL_GATE_CHECKER_FIRST_FAIL_EN
      ff_seen_q  <= 1'b0;
      ff_vec_q   <= '0;
      ff_obs_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      settle_q   <= settle_d;
      pass_cnt_q <= pass_cnt_d;
      err_q      <= err_d;
      mask_q     <= mask_d;
`ifdef UNIVERSAL_GATE_CHECKER_FIRST_FAIL_EN
      ff_seen_q  <= ff_seen_d;
      ff_vec_q   <= ff_vec_d;
      ff_obs_q   <= ff_obs_d;
`endif
    end
  end
endmodule

// File: tb/tb_universal_gate_checker.sv
// tb_universal_gate_checker: directed scenarios against default and saturating checker instances.
module tb_universal_gate_checker;
  logic clk, rst, start, start1;
  logic nand0, nor0, a0, b0, busy0, done0, pass0;
  logic [7:0] err0;
  logic [3:0] mask0;
  logic nand1, nor1, a1, b1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [3:0] mask1;
  int mode0;
  int checks, errors;
`ifdef UNIVERSAL_GATE_CHECKER_FIRST_FAIL_EN
  logic [1:0] ffv0, ffo0, ffv1, ffo1;
`endif
  universal_gate_checker u0 (
    .clk(clk), .rst(rst), .start(start), .nand_in(nand0), .nor_in(nor0),
    .a_out(a0), .b_out(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_mask(mask0)
`ifdef UNIVERSAL_GATE_CHECKER_FIRST_FAIL_EN
    , .first_fail_vec(ffv0), .first_fail_obs(ffo0)
`endif
  );
  universal_gate_checker #(.SETTLE_CYCLES(2), .PASSES(2), .ERR_W(3)) u1 (
    .clk(clk), .rst(rst), .start(start1), .nand_in(nand1), .nor_in(nor1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_mask(mask1)
`ifdef UNIVERSAL_GATE_CHECKER_FIRST_FAIL_EN
    , .first_fail_vec(ffv1), .first_fail_obs(ffo1)
`endif
  );
  // Gate models: 0 correct, 1 nand stuck at 0, 2 nand/nor swapped, 3 both inverted.
  always_comb begin
    nand0 = (mode0 == 1) ? 1'b0 : (mode0 == 2) ? ~(a0 | b0) : (mode0 == 3) ? (a0 & b0) : ~(a0 & b0);
    nor0  = (mode0 == 2) ? ~(a0 & b0) : (mode0 == 3) ? (a0 | b0) : ~(a0 | b0);
    nand1 = a1 & b1;
    nor1  = a1 | b1;
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic run0(input int repulse, output int lat, output int step_err);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    step_err = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == repulse) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      if (n < 12 && ({a0, b0} !== 2'(n / 3) || busy0 !== 1'b1)) step_err++;
      if (done0) begin
        lat = n;
        break;
      end
    end
  endtask
  task automatic test_reset();
    checks++;
    if ({a0, b0, busy0, done0, pass0, err0, mask0} !== 17'd0) begin
      errors++;
      $display("FAIL reset_u0: got %h expected 0", {a0, b0, busy0, done0, pass0, err0, mask0});
    end
    checks++;
    if ({a1, b1, busy1, done1, pass1, err1, mask1} !== 12'd0) begin
      errors++;
      $display("FAIL reset_u1: got %h expected 0", {a1, b1, busy1, done1, pass1, err1, mask1});
    end
  endtask
  task automatic test_correct();
    int lat, se;
    mode0 = 0;
    run0(0, lat, se);
    checks++;
    if (lat !== 12) begin errors++; $display("FAIL correct_latency: got %0d expected 12", lat); end
    checks++;
    if (se !== 0) begin errors++; $display("FAIL correct_vector_steps: got %0d bad cycles expected 0", se); end
    checks++;
    if ({busy0, pass0, err0, mask0} !== {1'b0, 1'b1, 8'd0, 4'b0000}) begin
      errors++;
      $display("FAIL correct_result: got busy=%b pass=%b err=%0d mask=%b expected 0 1 0 0000", busy0, pass0, err0, mask0);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({done0, pass0} !== 2'b11) begin errors++; $display("FAIL done_held: got %b expected 11", {done0, pass0}); end
  endtask
  task automatic test_nand_stuck();
    int lat, se;
    mode0 = 1;
    run0(0, lat, se);
    checks++;
    if (err0 !== 8'd3) begin errors++; $display("FAIL stuck_err: got %0d expected 3", err0); end
    checks++;
    if (mask0 !== 4'b0111) begin errors++; $display("FAIL stuck_mask: got %b expected 0111", mask0); end
    checks++;
    if (pass0 !== 1'b0 || done0 !== 1'b1) begin errors++; $display("FAIL stuck_pass: got pass=%b done=%b expected 0 1", pass0, done0); end
`ifdef UNIVERSAL_GATE_CHECKER_FIRST_FAIL_EN
    checks++;
    if ({ffv0, ffo0} !== 4'b0001) begin errors++; $display("FAIL stuck_first_fail: got vec=%b obs=%b expected 00 01", ffv0, ffo0); end
`endif
  endtask
  task automatic test_swapped();
    int lat, se;
    mode0 = 2;
    run0(0, lat, se);
    checks++;
    if (err0 !== 8'd4) begin errors++; $display("FAIL swap_err: got %0d expected 4", err0); end
    checks++;
    if (mask0 !== 4'b0110) begin errors++; $display("FAIL swap_mask: got %b expected 0110", mask0); end
    checks++;
    if (pass0 !== 1'b0) begin errors++; $display("FAIL swap_pass: got %b expected 0", pass0); end
  endtask
  task automatic test_saturation();
    int lat;
    lat = -1;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (done1) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat !== 24) begin errors++; $display("FAIL sat_latency: got %0d expected 24", lat); end
    checks++;
    if (err1 !== 3'd7) begin errors++; $display("FAIL sat_err: got %0d expected 7", err1); end
    checks++;
    if (mask1 !== 4'b1111) begin errors++; $display("FAIL sat_mask: got %b expected 1111", mask1); end
    checks++;
    if (pass1 !== 1'b0) begin errors++; $display("FAIL sat_pass: got %b expected 0", pass1); end
  endtask
  task automatic test_back_to_back();
    int lat, se;
    mode0 = 0;
    run0(5, lat, se);
    checks++;
    if (lat !== 12) begin errors++; $display("FAIL repulse_latency: got %0d expected 12", lat); end
    checks++;
    if (se !== 0 || pass0 !== 1'b1 || err0 !== 8'd0) begin
      errors++;
      $display("FAIL repulse_result: got steps=%0d pass=%b err=%0d expected 0 1 0", se, pass0, err0);
    end
  endtask
  task automatic test_mid_reset();
    int lat, se;
    mode0 = 3;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a0, b0, busy0, done0, pass0, err0, mask0} !== 17'd0) begin
      errors++;
      $display("FAIL midrun_reset: got %h expected 0", {a0, b0, busy0, done0, pass0, err0, mask0});
    end
    @(negedge clk) rst = 1'b0;
    mode0 = 0;
    run0(0, lat, se);
    checks++;
    if (lat !== 12 || se !== 0) begin errors++; $display("FAIL post_reset_latency: got %0d steps=%0d expected 12 0", lat, se); end
    checks++;
    if (pass0 !== 1'b1 || err0 !== 8'd0 || mask0 !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_result: got pass=%b err=%0d mask=%b expected 1 0 0000", pass0, err0, mask0);
    end
  endtask
  initial begin
    checks = 0;
    errors = 0;
    mode0 = 0;
    rst = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    #12;
    test_reset();
    @(negedge clk) rst = 1'b0;
    test_correct();
    test_nand_stuck();
    test_swapped();
    test_saturation();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/universal_gate_checker.md
Name: universal_gate_checker

Overview:
- Self-checking stimulus/response stage that wraps the NAND/NOR universal-gate block.
- Sits directly upstream and downstream of it:
  - drives the gate's `a`/`b` inputs through all four input combinations;
  - samples the gate's `nand_out`/`nor_out` after a programmable settle time;
  - compares against golden values and reports an error count, a per-vector fail mask and a pass flag.
- Used for on-chip/regression sign-off of the gate stage.

Parameters:
- SETTLE_CYCLES, 2, clocks held per vector before sampling; legal range >= 1.
- PASSES, 1, number of full 4-vector sweeps per run; legal range >= 1.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE.
- nand_in  input  1  DUT NAND result.
- nor_in  input  1  DUT NOR result.
- a_out  output  1  stimulus to DUT input a (registered).
- b_out  output  1  stimulus to DUT input b (registered).
- busy  output  1  run in progress.
- done  output  1  run complete; held until next accepted start.
- pass  output  1  1 when done and err_count==0.
- err_count  output  ERR_W  mismatch count, saturating.
- fail_mask  output  4  sticky; bit i set if vector i mismatched in any pass.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: all outputs 0; state IDLE; all internal counters 0.
- Reset mid-run: abort immediately to IDLE; all outputs 0; no done pulse.
- Vector order: index {a,b} = 00, 01, 10, 11, repeated PASSES times.
- Golden values: nand = ~(a&b), nor = ~(a|b).
- FSM states and transitions:
  - IDLE: busy=0. On a clock edge with start=1:
    - a_out/b_out <= 00, settle_cnt <= 0, pass_cnt <= 0;
    - err_count, fail_mask, done, pass cleared;
    - busy <= 1; go to SETTLE.
  - SETTLE: settle_cnt increments each clock. After SETTLE_CYCLES clocks in this state, go to SAMPLE.
  - SAMPLE: exactly one clock. At its closing edge:
    - compare nand_in and nor_in separately against golden values;
    - err_count += (nand mismatch) + (nor mismatch), i.e. 0..2 per sample, saturating at 2^ERR_W-1;
    - set fail_mask[vec] if either output mismatched.
    - If vec < 3: advance the vector, go to SETTLE.
    - Else if pass_cnt < PASSES-1: vec <= 00, pass_cnt++, go to SETTLE.
    - Else: go to DONE.
  - DONE: busy=0, done=1, pass=(err_count==0). Same behaviour as IDLE on start; otherwise remain in DONE.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 clocks.
  - done rises 4*PASSES*(SETTLE_CYCLES+1) clocks after the edge that accepted start (12 clocks at defaults).
  - busy falls on the same edge that done rises.
- start while busy: ignored, no restart.
- start held high continuously: a new run begins on the first edge in DONE.
- a_out/b_out: change only on SAMPLE-exit edges or the start-accept edge; stable throughout SETTLE.
- Settle counter width: $clog2(SETTLE_CYCLES+1). pass_cnt width: $clog2(PASSES+1).

Optional Feature:
- Macro: UNIVERSAL_GATE_CHECKER_FIRST_FAIL_EN.
- Defined: adds two outputs.
  - first_fail_vec[1:0]: vector index of the earliest mismatching sample in the run.
  - first_fail_obs[1:0]: observed {nand_in,nor_in} at that sample.
  - Both are captured once per run, cleared on start accept and on reset, and remain 0 if no mismatch occurs.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Correct gate model, defaults, start pulse -> done at +12 clocks, pass=1, err_count=0, fail_mask=0000; a_out/b_out step 00,01,10,11 every 3 clocks.
- nand_in stuck at 0, nor correct -> err_count=3, fail_mask=0111, pass=0; with FIRST_FAIL_EN: first_fail_vec=00, first_fail_obs=01.
- nand/nor wires swapped -> err_count=4, fail_mask=0110, pass=0.
- ERR_W=3, PASSES=2, both outputs inverted -> 16 raw mismatches, err_count saturates at 7, fail_mask=1111, done at +24 clocks.
- start re-pulsed at clock 5 of a run -> ignored; done still at +12 clocks with correct results.
- rst asserted at clock 7 of a run -> all outputs 0 asynchronously; a fresh start then completes normally with pass=1.
